fft_frame_streamer: RTL and testbench

// - AXI4-Stream master feeding time-domain ADC samples into the FFT core, whose output the trigger detector consumes.
// - Collects samples into 64-sample frames in a ping-pong RAM (two banks), then streams each full frame to the FFT core.
// - Asserts T_LAST on the final beat of every frame.
// - Reports dropped samples via a sticky overflow flag.

---
 rtl/fft_frame_streamer_pkg.sv | 34 +++
 rtl/fft_frame_streamer_if.sv | 13 +
 rtl/fft_pingpong_ram.sv | 26 ++
 rtl/fft_frame_streamer.sv | 189 ++++++++++++++++++
 tb/tb_fft_frame_streamer.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/fft_frame_streamer_pkg.sv
// Shared constants and types for the ADC-to-FFT frame streamer.
// The T_DATA field positions are also used by the trigger detector.
package fft_frame_streamer_pkg;

  localparam int FRAME_LEN = 64;
  localparam int ADDR_W    = 6;
  localparam int SAMPLE_W  = 16;
  localparam int TDATA_W   = 32;

  localparam int REAL_LSB  = 0;
  localparam int REAL_MSB  = 15;
  localparam int IMAG_LSB  = 16;
  localparam int IMAG_MSB  = 31;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_SEND
  } rd_state_e;

  typedef struct packed {
    logic [TDATA_W-1:0] data;
    logic               last;
  } beat_t;

  // Real-only complex word: imag part stays zero.
  function automatic logic [TDATA_W-1:0] pack_tdata(input logic [SAMPLE_W-1:0] s);
    logic [TDATA_W-1:0] d;
    d = '0;
    d[REAL_MSB:REAL_LSB] = s;
    return d;
  endfunction

endpackage

// File: rtl/fft_frame_streamer_if.sv
// AXI4-Stream link from the frame streamer to the FFT core.
interface fft_frame_streamer_if;
  import fft_frame_streamer_pkg::*;

  logic [TDATA_W-1:0] T_DATA;
  logic               T_VALID;
  logic               T_READY;
  logic               T_LAST;

  modport master (output T_DATA, output T_VALID, output T_LAST, input T_READY);
  modport slave  (input T_DATA, input T_VALID, input T_LAST, output T_READY);

endinterface

// File: rtl/fft_pingpong_ram.sv
// Simple dual-port RAM holding both ping-pong frame banks; registered read.
module fft_pingpong_ram #(
  parameter int DATA_W = 32,
  parameter int AW     = 7
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**AW];
  logic [DATA_W-1:0] rdata_q;

  // No reset so the array maps onto block RAM.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/fft_frame_streamer.sv
// Captures ADC samples into ping-pong frame banks and streams each full
// frame to the FFT core over AXI4-Stream with back-to-back beats.
module fft_frame_streamer
  import fft_frame_streamer_pkg::*;
(
  input  logic                clk,
  input  logic                reset_b,
  input  logic                Enable,
  input  logic [SAMPLE_W-1:0] Sample,
  input  logic                Sample_Valid,
  input  logic                Clear_Overflow,
  output logic                Overflow,
  output logic [15:0]         Frame_Count,
  fft_frame_streamer_if.master axis
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_LEN - 1);

  // write side
  logic              wbank_q, wbank_d;
  logic [ADDR_W-1:0] wptr_q, wptr_d;
  logic [1:0]        bank_full_q, bank_full_d;
  logic              ovf_q, ovf_d;

  // read side
  rd_state_e         state_q, state_d;
  logic              rbank_q, rbank_d;
  logic [ADDR_W-1:0] rptr_q, rptr_d;
  logic              rd_done_q, rd_done_d;
  logic              rd_vld_q, rd_vld_d;
  logic              rd_last_q, rd_last_d;
  beat_t             out_q, out_d;
  logic              out_vld_q, out_vld_d;
  beat_t             skid_q, skid_d;
  logic              skid_vld_q, skid_vld_d;
  logic [15:0]       frame_cnt_q, frame_cnt_d;

  logic               wr_req, wr_en, drop, fill;
  logic               pop, frame_done, issue;
  logic [1:0]         occ;
  logic [TDATA_W-1:0] rdata;

  assign wr_req = Sample_Valid & Enable;
  assign wr_en  = wr_req & ~bank_full_q[wbank_q];
  assign drop   = wr_req &  bank_full_q[wbank_q];
  assign fill   = wr_en & (wptr_q == LAST_ADDR);

  assign pop        = out_vld_q & axis.T_READY;
  assign frame_done = (state_q == ST_SEND) & pop & out_q.last;
  // Words held or in flight once this cycle's pop retires; at most two fit.
  assign occ = 2'(out_vld_q) + 2'(skid_vld_q) + 2'(rd_vld_q) - 2'(pop);

  always_comb begin
    wptr_d  = wptr_q;
    wbank_d = wbank_q;
    ovf_d   = ovf_q;
    if (!Enable)    wptr_d = '0;
    else if (wr_en) wptr_d = wptr_q + 1'b1;
    if (fill) wbank_d = ~wbank_q;
    if (Clear_Overflow) ovf_d = 1'b0;
    if (drop)           ovf_d = 1'b1;
  end

  // Fill and frame-done always target different banks, so both can apply.
  always_comb begin
    bank_full_d = bank_full_q;
    if (frame_done) bank_full_d[rbank_q] = 1'b0;
    if (fill)       bank_full_d[wbank_q] = 1'b1;
  end

  always_comb begin
    state_d     = state_q;
    rbank_d     = rbank_q;
    rptr_d      = rptr_q;
    rd_done_d   = rd_done_q;
    out_d       = out_q;
    out_vld_d   = out_vld_q;
    skid_d      = skid_q;
    skid_vld_d  = skid_vld_q;
    frame_cnt_d = frame_cnt_q;
    issue       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bank_full_q[rbank_q]) begin
          issue   = 1'b1;
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        issue   = ~rd_done_q & (occ <= 2'd1);
        state_d = ST_SEND;
      end
      ST_SEND: begin
        issue = ~rd_done_q & (occ <= 2'd1);
        if (frame_done) begin
          state_d     = ST_IDLE;
          rbank_d     = ~rbank_q;
          rd_done_d   = 1'b0;
          frame_cnt_d = frame_cnt_q + 16'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (issue) begin
      rptr_d = rptr_q + 1'b1;
      if (rptr_q == LAST_ADDR) rd_done_d = 1'b1;
    end

    // Retire the accepted beat, then slot the returning RAM word.
    if (pop) begin
      if (skid_vld_q) begin
        out_d      = skid_q;
        skid_vld_d = 1'b0;
      end else begin
        out_vld_d = 1'b0;
      end
    end
    if (rd_vld_q) begin
      if (!out_vld_d) begin
        out_d     = '{data: rdata, last: rd_last_q};
        out_vld_d = 1'b1;
      end else begin
        skid_d     = '{data: rdata, last: rd_last_q};
        skid_vld_d = 1'b1;
      end
    end
  end

  assign rd_vld_d  = issue;
  assign rd_last_d = issue & (rptr_q == LAST_ADDR);

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      wbank_q     <= 1'b0;
      wptr_q      <= '0;
      bank_full_q <= '0;
      ovf_q       <= 1'b0;
      state_q     <= ST_IDLE;
      rbank_q     <= 1'b0;
      rptr_q      <= '0;
      rd_done_q   <= 1'b0;
      rd_vld_q    <= 1'b0;
      rd_last_q   <= 1'b0;
      out_q       <= '0;
      out_vld_q   <= 1'b0;
      skid_q      <= '0;
      skid_vld_q  <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      wbank_q     <= wbank_d;
      wptr_q      <= wptr_d;
      bank_full_q <= bank_full_d;
      ovf_q       <= ovf_d;
      state_q     <= state_d;
      rbank_q     <= rbank_d;
      rptr_q      <= rptr_d;
      rd_done_q   <= rd_done_d;
      rd_vld_q    <= rd_vld_d;
      rd_last_q   <= rd_last_d;
      out_q       <= out_d;
      out_vld_q   <= out_vld_d;
      skid_q      <= skid_d;
      skid_vld_q  <= skid_vld_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  fft_pingpong_ram #(
    .DATA_W (TDATA_W),
    .AW     (ADDR_W + 1)
  ) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr ({wbank_q, wptr_q}),
    .wdata (pack_tdata(Sample)),
    .re    (issue),
    .raddr ({rbank_q, rptr_q}),
    .rdata (rdata)
  );

  assign axis.T_DATA  = out_q.data;
  assign axis.T_VALID = out_vld_q;
  assign axis.T_LAST  = out_q.last;
  assign Overflow     = ovf_q;
  assign Frame_Count  = frame_cnt_q;

endmodule

// File: tb/tb_fft_frame_streamer.sv
// Directed bench for fft_frame_streamer: framing, back-pressure, overflow,
// partial-frame discard, sustained streaming and asynchronous reset.
module tb_fft_frame_streamer;

  logic        clk;
  logic        reset_b;
  logic        Enable;
  logic [15:0] Sample;
  logic        Sample_Valid;
  logic        Clear_Overflow;
  logic        Overflow;
  logic [15:0] Frame_Count;

  fft_frame_streamer_if axis();

  fft_frame_streamer dut (
    .clk            (clk),
    .reset_b        (reset_b),
    .Enable         (Enable),
    .Sample         (Sample),
    .Sample_Valid   (Sample_Valid),
    .Clear_Overflow (Clear_Overflow),
    .Overflow       (Overflow),
    .Frame_Count    (Frame_Count),
    .axis           (axis)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          total = 0;
  int          bad   = 0;
  bit          rnd_ready = 1'b0;
  logic [31:0] got_data[$];
  logic        got_last[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: log accepted beat, step, then verify any stalled beat held.
  task automatic tick();
    logic        hold;
    logic [31:0] hold_data;
    logic        hold_last;
    if (axis.T_VALID && axis.T_READY) begin
      got_data.push_back(axis.T_DATA);
      got_last.push_back(axis.T_LAST);
    end
    hold      = axis.T_VALID && !axis.T_READY;
    hold_data = axis.T_DATA;
    hold_last = axis.T_LAST;
    @(posedge clk);
    #1;
    if (hold) begin
      chk("stall_valid", 32'(axis.T_VALID), 32'd1);
      chk("stall_data", axis.T_DATA, hold_data);
      chk("stall_last", 32'(axis.T_LAST), 32'(hold_last));
    end
    if (rnd_ready) axis.T_READY = 1'($urandom_range(0, 1));
  endtask

  task automatic send_run(input int start, input int n);
    for (int i = 0; i < n; i++) begin
      Sample       = 16'(start + i);
      Sample_Valid = 1'b1;
      tick();
    end
    Sample_Valid = 1'b0;
  endtask

  // Full frame, then first T_VALID expected exactly two edges after the fill.
  task automatic send_frame(input string tag, input int start);
    send_run(start, 64);
    tick();
    chk({tag, "_lat1"}, 32'(axis.T_VALID), 32'd0);
    tick();
    chk({tag, "_lat2"}, 32'(axis.T_VALID), 32'd1);
  endtask

  task automatic drain(input string tag, input int n, input int start);
    int lim;
    lim = n * 4 + 200;
    while (got_data.size() < n && lim > 0) begin
      tick();
      lim--;
    end
    chk({tag, "_count"}, 32'(got_data.size()), 32'(n));
    for (int i = 0; i < n && i < got_data.size(); i++) begin
      chk({tag, "_data"}, got_data[i], {16'h0000, 16'(start + i)});
      chk({tag, "_last"}, 32'(got_last[i]), 32'((i % 64) == 63));
    end
    got_data.delete();
    got_last.delete();
  endtask

  initial begin
    int lim;
    reset_b        = 1'b0;
    Enable         = 1'b0;
    Sample         = '0;
    Sample_Valid   = 1'b0;
    Clear_Overflow = 1'b0;
    axis.T_READY   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 32'(axis.T_VALID), 32'd0);
    chk("rst_data", axis.T_DATA, 32'd0);
    chk("rst_last", 32'(axis.T_LAST), 32'd0);
    chk("rst_ovf", 32'(Overflow), 32'd0);
    chk("rst_fcnt", 32'(Frame_Count), 32'd0);
    reset_b = 1'b1;
    Enable  = 1'b1;
    tick();

    // single frame 0..63, always ready
    axis.T_READY = 1'b1;
    send_frame("f1", 0);
    drain("f1", 64, 0);
    chk("f1_fcnt", 32'(Frame_Count), 32'd1);

    // three frames under random back-pressure
    rnd_ready = 1'b1;
    for (int f = 0; f < 3; f++) begin
      send_frame("rr", 1000 + 64 * f);
      drain("rr", 64, 1000 + 64 * f);
    end
    rnd_ready    = 1'b0;
    axis.T_READY = 1'b1;
    tick();
    chk("rr_fcnt", 32'(Frame_Count), 32'd4);
    chk("rr_ovf", 32'(Overflow), 32'd0);

    // both banks fill with sink stalled; samples 128 and 129 dropped
    axis.T_READY = 1'b0;
    send_run(0, 130);
    chk("ov_flag", 32'(Overflow), 32'd1);
    chk("ov_fcnt", 32'(Frame_Count), 32'd4);
    Clear_Overflow = 1'b1;
    Sample         = 16'd999;
    Sample_Valid   = 1'b1;
    tick();
    Clear_Overflow = 1'b0;
    Sample_Valid   = 1'b0;
    chk("ov_set_wins", 32'(Overflow), 32'd1);
    axis.T_READY = 1'b1;
    drain("ov", 128, 0);
    chk("ov_fcnt2", 32'(Frame_Count), 32'd6);
    chk("ov_sticky", 32'(Overflow), 32'd1);
    Clear_Overflow = 1'b1;
    tick();
    Clear_Overflow = 1'b0;
    chk("ov_clear", 32'(Overflow), 32'd0);

    // partial frame discarded by dropping Enable
    send_run(500, 40);
    Enable = 1'b0;
    tick();
    Enable = 1'b1;
    send_frame("pf", 100);
    drain("pf", 64, 100);
    chk("pf_fcnt", 32'(Frame_Count), 32'd7);
    repeat (20) tick();
    chk("pf_extra", 32'(got_data.size()), 32'd0);
    chk("pf_idle", 32'(axis.T_VALID), 32'd0);

    // ten frames at one sample per cycle with a 4-cycle gap between frames
    for (int k = 0; k < 10; k++) begin
      send_frame("cs", 2000 + 64 * k);
      tick();
      tick();
    end
    drain("cs", 640, 2000);
    chk("cs_fcnt", 32'(Frame_Count), 32'd17);
    chk("cs_ovf", 32'(Overflow), 32'd0);

    // asynchronous reset while beat 20 is on the bus
    send_frame("rs", 300);
    lim = 200;
    while (got_data.size() < 20 && lim > 0) begin
      tick();
      lim--;
    end
    chk("rs_beats", 32'(got_data.size()), 32'd20);
    chk("rs_pre_valid", 32'(axis.T_VALID), 32'd1);
    reset_b = 1'b0;
    #1;
    chk("rs_valid", 32'(axis.T_VALID), 32'd0);
    chk("rs_data", axis.T_DATA, 32'd0);
    chk("rs_last", 32'(axis.T_LAST), 32'd0);
    chk("rs_fcnt", 32'(Frame_Count), 32'd0);
    got_data.delete();
    got_last.delete();
    repeat (2) @(posedge clk);
    #1;
    reset_b = 1'b1;
    tick();
    send_frame("ar", 400);
    drain("ar", 64, 400);
    chk("ar_fcnt", 32'(Frame_Count), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
